pulse_gen: RTL and testbench



---
 rtl/pulse_gen.sv | 118 +++++++++++
 tb/tb_pulse_gen.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// Delayed single-pulse generator triggered by a rising edge on pulse_start.
// Optional 2-flop start synchronizer: define PULSE_GEN_SYNC_EN.
module pulse_gen #(
    parameter int CNT_W    = 32,
    parameter int PCOUNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pulse_start,
    input  logic [CNT_W-1:0]    pulse_delay,
    input  logic [CNT_W-1:0]    pulse_width,
    output logic                pulse_out,
    output logic                busy,
    output logic                done,
    output logic [PCOUNT_W-1:0] pulse_count
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] width_q;
    logic             start_s;
    logic             start_d;
    logic             trig;

`ifdef PULSE_GEN_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for a start level from another clock domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], pulse_start};
    end

    assign start_s = sync_q[1];
`else
    assign start_s = pulse_start;
`endif

    // Previous start level; reset to 0 so a level high at release triggers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) start_d <= 1'b0;
        else          start_d <= start_s;
    end

    assign trig = start_s & ~start_d;

    // Sequencer: count down the delay, then the high time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            width_q     <= '0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        width_q <= pulse_width;
                        if (pulse_delay != '0) begin
                            state <= DELAY;
                            cnt   <= pulse_delay - CNT_W'(1);
                            busy  <= 1'b1;
                        end else if (pulse_width != '0) begin
                            state     <= HIGH;
                            cnt       <= pulse_width - CNT_W'(1);
                            pulse_out <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (cnt == '0) begin
                        if (width_q != '0) begin
                            state     <= HIGH;
                            cnt       <= width_q - CNT_W'(1);
                            pulse_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        state       <= IDLE;
                        pulse_out   <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pulse_count <= pulse_count + PCOUNT_W'(1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: per-cycle {pulse_out,busy,done} vectors.
// Define PULSE_GEN_SYNC_EN to bench the synchronized build.
module tb_pulse_gen;

`ifdef PULSE_GEN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pulse_start = 1'b0;
    logic [31:0] pulse_delay = '0;
    logic [31:0] pulse_width = '0;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [1:0]  pulse_count;

    int nvec = 0;
    int nbad = 0;
    int cnt_exp = 0;

    pulse_gen #(
        .CNT_W    (32),
        .PCOUNT_W (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pulse_start (pulse_start),
        .pulse_delay (pulse_delay),
        .pulse_width (pulse_width),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One triggered sequence; edge offsets j are relative to trigger edge T.
    // chg_j: after edge T+chg_j set pulse_width to 100.
    // rt_j: drop pulse_start after T+rt_j-2, raise it after T+rt_j-1.
    // rst_j: assert reset after edge T+rst_j and stop there.
    task automatic run(input int d, input int w, input int chg_j,
                       input int rt_j, input int rst_j);
        logic [2:0] e;
        pulse_start = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        pulse_delay = 32'(d);
        pulse_width = 32'(w);
        @(posedge clk);
        #1;
        pulse_start = 1'b1;
        for (int j = -LAT; j <= d + w + 2; j++) begin
            @(posedge clk);
            #1;
            if (j < 0) e = 3'b000;
            else if (d == 0 && w == 0) e = {2'b00, j == 0};
            else e = {j >= d && j < d + w, j < d + w, j == d + w};
            chk($sformatf("seq d%0d w%0d j%0d", d, w, j), 32'(
                {pulse_out, busy, done}), 32'(e));
            if (j == chg_j) pulse_width = 32'd100;
            if (j == rt_j - 2) pulse_start = 1'b0;
            if (j == rt_j - 1) pulse_start = 1'b1;
            if (j == rst_j) begin
                reset_n = 1'b0;
                #1;
                chk("rst outs", 32'({pulse_out, busy, done}), 32'(3'b000));
                cnt_exp = 0;
                chk("rst count", 32'(pulse_count), 32'(cnt_exp));
                return;
            end
        end
        if (w > 0) cnt_exp = (cnt_exp + 1) % 4;
        chk($sformatf("count d%0d w%0d", d, w), 32'(pulse_count),
            32'(cnt_exp));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset outs", 32'({pulse_out, busy, done}), 32'(3'b000));
        chk("reset count", 32'(pulse_count), 32'(0));
        reset_n = 1'b1;
        run(5, 3, -99, -99, -99);
        run(0, 1, -99, -99, -99);
        run(0, 0, -99, -99, -99);
        run(10, 10, -99, 4, -99);
        run(4, 3, 1, -99, -99);
        run(2, 0, -99, -99, -99);
        run(5, 3, -99, -99, 6);
        #3;
        pulse_start = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run(1, 1, -99, -99, -99);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
